// File: rtl/mac_op_sequencer.sv
// Control stage in front of the 8-bit MAC: accepts one command at a time, drives the
// MAC for two identical cycles so both loop registers settle, then returns the result.
module mac_op_sequencer #(
  parameter int SAT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [7:0]              op_in_1,
  input  logic [7:0]              op_in_2,
  input  logic [7:0]              op_in_add,
  input  logic [1:0]              op_mode,
  output logic [7:0]              mac_in_1,
  output logic [7:0]              mac_in_2,
  output logic [7:0]              mac_in_add,
  output logic                    mac_mul_sel,
  output logic                    mac_add_sel,
  input  logic [24:0]             mac_output,
  output logic                    result_valid,
  output logic [24:0]             result,
  output logic [SAT_W-1:0]        result_sat,
  output logic                    sat_flag,
  output logic [CNT_W-1:0]        op_count
);

  typedef enum logic [1:0] {IDLE, EXEC0, EXEC1, DONE} state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [1:0] mode;
  } op_t;

  localparam logic signed [24:0] SAT_MAX = 25'((1 <<< (SAT_W - 1)) - 1);
  localparam logic signed [24:0] SAT_MIN = -SAT_MAX - 25'sd1;

  state_e            state_q, state_d;
  op_t               op_q, op_d;
  logic [24:0]       result_q, result_d;
  logic [SAT_W-1:0]  result_sat_q, result_sat_d;
  logic              sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;
  logic              result_valid_q, result_valid_d;

  logic signed [24:0] mac_s;
  logic [SAT_W-1:0]   clamp_val;
  logic               clamp_hit;

  assign mac_s = $signed(mac_output);

  always_comb begin
    clamp_val = mac_s[SAT_W-1:0];
    clamp_hit = 1'b0;
    if (mac_s > SAT_MAX) begin
      clamp_val = SAT_MAX[SAT_W-1:0];
      clamp_hit = 1'b1;
    end else if (mac_s < SAT_MIN) begin
      clamp_val = SAT_MIN[SAT_W-1:0];
      clamp_hit = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    result_d       = result_q;
    result_sat_d   = result_sat_q;
    sat_flag_d     = sat_flag_q;
    op_count_d     = op_count_q;
    result_valid_d = 1'b0;
    op_ready       = 1'b0;
    // HOLD: MAC recirculates 0*0 + ACC, which is stable once both loop registers agree
    mac_in_1       = 8'd0;
    mac_in_2       = 8'd0;
    mac_in_add     = 8'd0;
    mac_mul_sel    = 1'b0;
    mac_add_sel    = 1'b1;
    case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          op_d    = '{a: op_in_1, b: op_in_2, c: op_in_add, mode: op_mode};
          state_d = EXEC0;
        end
      end
      EXEC0, EXEC1: begin
        // Same drive twice: EXEC1 still sees the old ACC, so both registers land on the result
        mac_in_1    = op_q.a;
        mac_in_2    = op_q.b;
        mac_in_add  = op_q.c;
        mac_mul_sel = op_q.mode[1];
        mac_add_sel = op_q.mode[0];
        state_d     = (state_q == EXEC0) ? EXEC1 : DONE;
      end
      DONE: begin
        result_d       = mac_output;
        result_sat_d   = clamp_val;
        sat_flag_d     = clamp_hit;
        op_count_d     = op_count_q + CNT_W'(1);
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= '0;
      result_q       <= '0;
      result_sat_q   <= '0;
      sat_flag_q     <= 1'b0;
      op_count_q     <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      result_q       <= result_d;
      result_sat_q   <= result_sat_d;
      sat_flag_q     <= sat_flag_d;
      op_count_q     <= op_count_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_sat   = result_sat_q;
  assign sat_flag     = sat_flag_q;
  assign op_count     = op_count_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mac_op_sequencer.sv
// Bench for mac_op_sequencer: cycle model of the MAC loop, arithmetic reference for results,
// directed vector table, continuous-valid, reset-abort and randomized op streams.
module tb_mac_op_sequencer;
  localparam int SAT_W = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              op_valid, op_ready;
  logic [7:0]        op_in_1, op_in_2, op_in_add;
  logic [1:0]        op_mode;
  logic [7:0]        mac_in_1, mac_in_2, mac_in_add;
  logic              mac_mul_sel, mac_add_sel;
  logic signed [24:0] mac_output;
  logic              result_valid;
  logic signed [24:0] result;
  logic signed [SAT_W-1:0] result_sat;
  logic              sat_flag;
  logic [CNT_W-1:0]  op_count;

  mac_op_sequencer #(.SAT_W(SAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_in_1(op_in_1), .op_in_2(op_in_2), .op_in_add(op_in_add), .op_mode(op_mode),
    .mac_in_1(mac_in_1), .mac_in_2(mac_in_2), .mac_in_add(mac_in_add),
    .mac_mul_sel(mac_mul_sel), .mac_add_sel(mac_add_sel),
    .mac_output(mac_output),
    .result_valid(result_valid), .result(result), .result_sat(result_sat),
    .sat_flag(sat_flag), .op_count(op_count)
  );

  // MAC environment: adder_out register feeding the intermediate (ACC) register
  logic signed [24:0] mac_r1, mac_r2, mac_sum;
  logic signed [7:0]  mi1, mi2, madd;
  logic signed [32:0] mprod_full;
  logic signed [23:0] mprod;
  assign mi1  = mac_in_1;
  assign mi2  = mac_in_2;
  assign madd = mac_in_add;
  assign mprod_full = (mac_mul_sel ? 33'(mac_r2) : 33'(mi1)) * 33'(mi2);
  assign mprod = mprod_full[23:0];
  assign mac_sum = 25'(mprod) + (mac_add_sel ? mac_r2 : 25'(madd));
  assign mac_output = mac_r2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_r1 <= '0;
      mac_r2 <= '0;
    end else begin
      mac_r1 <= mac_sum;
      mac_r2 <= mac_r1;
    end
  end

  int checks = 0;
  int failures = 0;
  longint acc_m;
  int cnt_m;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic longint ref_mac(input logic [1:0] mode, input logic signed [7:0] a,
                                     input logic signed [7:0] b, input logic signed [7:0] c,
                                     input longint acc);
    longint m, p, s;
    m = mode[1] ? acc : longint'(a);
    p = m * longint'(b);
    p = (p <<< 40) >>> 40;
    s = p + (mode[0] ? acc : longint'(c));
    s = (s <<< 39) >>> 39;
    return s;
  endfunction

  function automatic longint ref_sat(input longint r);
    longint mx, mn;
    mx = (longint'(1) <<< (SAT_W - 1)) - 1;
    mn = -mx - 1;
    if (r > mx) return mx;
    if (r < mn) return mn;
    return r;
  endfunction

  task automatic do_op(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input bit use_tbl, input longint er,
                       input longint es, input bit ef);
    int w;
    longint exp_r, exp_s;
    bit exp_f;
    w = 0;
    while (!op_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!op_ready) chk("ready_timeout", 0, 1);
    op_valid = 1'b1; op_mode = mode; op_in_1 = a; op_in_2 = b; op_in_add = c;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_in_1 = 8'($urandom); op_in_2 = 8'($urandom); op_in_add = 8'($urandom);
    op_mode = 2'($urandom);
    if (use_tbl) begin
      exp_r = er; exp_s = es; exp_f = ef;
    end else begin
      exp_r = ref_mac(mode, a, b, c, acc_m);
      exp_s = ref_sat(exp_r);
      exp_f = (exp_s != exp_r);
    end
    acc_m = exp_r;
    cnt_m++;
    @(negedge clk);
    chk("exec0_mul_sel", mac_mul_sel, mode[1]);
    chk("exec0_add_sel", mac_add_sel, mode[0]);
    chk("exec0_in_1", mac_in_1, a);
    chk("exec0_in_2", mac_in_2, b);
    chk("exec0_in_add", mac_in_add, c);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      chk("busy_ready", op_ready, 0);
      chk("busy_valid", result_valid, 0);
    end
    @(negedge clk);
    chk("result_valid", result_valid, 1);
    chk("result", result, exp_r);
    chk("result_sat", result_sat, exp_s);
    chk("sat_flag", sat_flag, exp_f);
    chk("op_count", op_count, longint'(CNT_W'(cnt_m)));
    chk("ready_after", op_ready, 1);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a, b, c;
    longint     exp_r, exp_s;
    bit         exp_f;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{2'b00, 8'd3,   8'd4,   8'd5,   17,       17,     0};
    tbl[1]  = '{2'b00, 8'd2,   8'd3,   8'd0,   6,        6,      0};
    tbl[2]  = '{2'b01, 8'd4,   8'd5,   8'd0,   26,       26,     0};
    tbl[3]  = '{2'b11, 8'd0,   8'd2,   8'd0,   78,       78,     0};
    tbl[4]  = '{2'b00, 8'h80,  8'h80,  8'h7f,  16511,    16511,  0};
    tbl[5]  = '{2'b01, 8'h80,  8'h80,  8'd0,   32895,    32767,  1};
    tbl[6]  = '{2'b01, 8'h7f,  8'h7f,  8'd0,   49024,    32767,  1};
    tbl[7]  = '{2'b11, 8'd0,   8'hff,  8'd0,   0,        0,      0};
    tbl[8]  = '{2'b10, 8'd0,   8'h80,  8'h80,  -128,     -128,   0};
    tbl[9]  = '{2'b01, 8'h80,  8'h7f,  8'd0,   -16384,   -16384, 0};
    tbl[10] = '{2'b01, 8'h80,  8'h7f,  8'd0,   -32640,   -32640, 0};
    tbl[11] = '{2'b01, 8'h80,  8'h7f,  8'd0,   -48896,   -32768, 1};
    tbl[12] = '{2'b10, 8'd0,   8'd100, 8'd7,   -4889593, -32768, 1};

    op_valid = 1'b0; op_in_1 = '0; op_in_2 = '0; op_in_add = '0; op_mode = '0;
    reset = 1'b1;
    acc_m = 0; cnt_m = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", op_ready, 1);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_sat", result_sat, 0);
    chk("rst_flag", sat_flag, 0);
    chk("rst_count", op_count, 0);
    chk("rst_hold_in", {mac_in_1, mac_in_2, mac_in_add}, 0);
    chk("rst_hold_sel", {mac_mul_sel, mac_add_sel}, 1);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i])
      do_op(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].c, 1'b1,
            tbl[i].exp_r, tbl[i].exp_s, tbl[i].exp_f);

    // MAC must stay put while the sequencer idles in HOLD
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_mac_output", mac_output, acc_m);
      chk("hold_no_valid", result_valid, 0);
    end

    // op_valid held high: accepts every 4 cycles
    op_valid = 1'b1; op_mode = 2'b00; op_in_1 = 8'd1; op_in_2 = 8'd2; op_in_add = 8'd3;
    for (int i = 0; i <= 12; i++) begin
      chk("cont_ready", op_ready, (i % 4 == 0));
      chk("cont_valid", result_valid, (i % 4 == 0) && (i > 0));
      if (i % 4 == 0 && i > 0) begin
        cnt_m++;
        acc_m = 5;
        chk("cont_result", result, 5);
        chk("cont_count", op_count, longint'(CNT_W'(cnt_m)));
      end
      if (i == 12) op_valid = 1'b0;
      @(negedge clk);
    end

    // reset while in EXEC1 drops the op
    do_op(2'b00, 8'd5, 8'd5, 8'd5, 1'b0, 0, 0, 0);
    op_valid = 1'b1; op_mode = 2'b00; op_in_1 = 8'd9; op_in_2 = 8'd9; op_in_add = 8'd9;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_ready", op_ready, 1);
    chk("abort_valid", result_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    acc_m = 0; cnt_m = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_valid", result_valid, 0);
      chk("abort_count", op_count, 0);
    end
    do_op(2'b01, 8'd1, 8'd1, 8'd0, 1'b1, 1, 1, 0);

    // randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      do_op(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
